// File: rtl/dram_refresh_scheduler_if.sv
// Refresh-scheduler <-> command-scheduler handshake bundle.
// Pure wiring, no latency.
// Scheduler backpressure is the grant: no grant means the request holds.
interface dram_refresh_scheduler_if;
  logic       init_done_i;
  logic       banks_idle_i;
  logic       ref_grant_i;
  logic       ref_req_o;
  logic       ref_urgent_o;
  logic       ref_busy_o;
  logic [1:0] cmd_o;
  logic [3:0] pending_cnt_o;
  logic       error_o;

  // Refresh block side: drives request, command and status.
  modport master (
    input  init_done_i,
    input  banks_idle_i,
    input  ref_grant_i,
    output ref_req_o,
    output ref_urgent_o,
    output ref_busy_o,
    output cmd_o,
    output pending_cnt_o,
    output error_o
  );

  // Scheduler / init side: drives init level, bank state and grant.
  modport slave (
    output init_done_i,
    output banks_idle_i,
    output ref_grant_i,
    input  ref_req_o,
    input  ref_urgent_o,
    input  ref_busy_o,
    input  cmd_o,
    input  pending_cnt_o,
    input  error_o
  );
endinterface

// File: rtl/dram_refresh_scheduler.sv
// Periodic auto-refresh: counts owed refreshes per tREFI, issues PREA/REF when granted.
// Grant in N -> PREA or REF in N+1; REF at N+1+TRP_CYCLES after PREA; bus released TRFC_CYCLES after REF.
// Without a grant refreshes are postponed up to MAX_POSTPONE, then urgent is raised; overflow sets a sticky error.
module dram_refresh_scheduler #(
  parameter int TREFI_CYCLES = 7800,
  parameter int TRFC_CYCLES  = 260,
  parameter int TRP_CYCLES   = 14,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  dram_refresh_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHARGE,
    S_WAIT_TRP,
    S_REFRESH,
    S_WAIT_TRFC
  } state_t;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PREA = 2'b01;
  localparam logic [1:0] CMD_REF  = 2'b10;

  // Wait states are entered one cycle after the command, so they last
  // (delay - 1) cycles; the down-counter is loaded with (delay - 2).
  // TRP_CYCLES and TRFC_CYCLES must therefore be at least 2.
  localparam logic [CNT_W-1:0] IVL_LAST  = CNT_W'(TREFI_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'(TRP_CYCLES - 2);
  localparam logic [CNT_W-1:0] TRFC_LOAD = CNT_W'(TRFC_CYCLES - 2);
  // pending_cnt_o is 4 bits wide, so MAX_POSTPONE must not exceed 15.
  localparam logic [3:0]       PEND_MAX  = 4'(MAX_POSTPONE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [3:0]       pend_q, pend_d;
  logic             err_q;
  logic             err_set;
  logic             tick;
  logic             accept;
  logic             issue_ref;

  logic             req_q, req_d;
  logic             urgent_q, urgent_d;
  logic             busy_q, busy_d;
  logic [1:0]       cmd_q, cmd_d;

  logic             init_done;
  assign init_done = bus.init_done_i;

  // A grant only counts while the registered request is visible to the scheduler.
  assign accept = (state_q == S_IDLE) && req_q && bus.ref_grant_i;

  // Interval counter: free-runs 0..TREFI-1 while initialised, wrap cycle is the tick.
  always_comb begin
    tick  = init_done && (ivl_q == IVL_LAST);
    ivl_d = ivl_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (!init_done || tick) begin
      ivl_d = '0;
    end
  end

  // Refresh sequence next-state; losing init_done aborts anything in flight.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    issue_ref = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.banks_idle_i) begin
            state_d   = S_REFRESH;
            issue_ref = 1'b1;
          end else begin
            state_d = S_PRECHARGE;
          end
        end
      end
      S_PRECHARGE: begin
        state_d = S_WAIT_TRP;
        dly_d   = TRP_LOAD;
      end
      S_WAIT_TRP: begin
        if (dly_q == '0) begin
          state_d   = S_REFRESH;
          issue_ref = 1'b1;
        end else begin
          dly_d = dly_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_REFRESH: begin
        state_d = S_WAIT_TRFC;
        dly_d   = TRFC_LOAD;
      end
      S_WAIT_TRFC: begin
        if (dly_q == '0) begin
          state_d = S_IDLE;
        end else begin
          dly_d = dly_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!init_done) begin
      state_d   = S_IDLE;
      dly_d     = '0;
      issue_ref = 1'b0;
    end
  end

  // Owed-refresh count: tick adds, REF subtracts, both together cancel out.
  always_comb begin
    pend_d  = pend_q;
    err_set = 1'b0;
    if (!init_done) begin
      pend_d = '0;
    end else if (tick && !issue_ref) begin
      if (pend_q == PEND_MAX) begin
        err_set = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (issue_ref && !tick) begin
      if (pend_q != '0) begin
        pend_d = pend_q - 4'd1;
      end
    end
  end

  // Outputs are decoded from next-state values so they can be registered with no extra lag.
  always_comb begin
    req_d    = (state_d == S_IDLE) && (pend_d != '0);
    urgent_d = (pend_d == PEND_MAX);
    busy_d   = (state_d != S_IDLE);
    cmd_d    = CMD_NOP;
    case (state_d)
      S_PRECHARGE: cmd_d = CMD_PREA;
      S_REFRESH:   cmd_d = CMD_REF;
      default:     cmd_d = CMD_NOP;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, sticky error and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ivl_q    <= '0;
      dly_q    <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
      busy_q   <= 1'b0;
      cmd_q    <= CMD_NOP;
    end else begin
      ivl_q    <= ivl_d;
      dly_q    <= dly_d;
      pend_q   <= pend_d;
      err_q    <= err_q | err_set;
      req_q    <= req_d;
      urgent_q <= urgent_d;
      busy_q   <= busy_d;
      cmd_q    <= cmd_d;
    end
  end

  assign bus.ref_req_o     = req_q;
  assign bus.ref_urgent_o  = urgent_q;
  assign bus.ref_busy_o    = busy_q;
  assign bus.cmd_o         = cmd_q;
  assign bus.pending_cnt_o = pend_q;
  assign bus.error_o       = err_q;

endmodule
